seq_det_ctrl: RTL

Run controller for a programmable bit-serial pattern detector. It holds the pattern, length, match threshold and timeout window, and arms detection on a start command. It produces a Mealy hit pulse per match and counts matches. It ends a run with done when the threshold is reached, or with timeout when the window expires. It sits between the register interface and the serial input stream, replacing hard-coded fixed-pattern detectors.

---
 rtl/seq_det_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run controller for a programmable bit-serial pattern detector.
// Optional sticky interrupt output is enabled by defining SEQ_DET_CTRL_IRQ_EN.
module seq_det_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8,
  parameter int OVERLAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [PW-1:0]          cfg_pat,
  input  logic [$clog2(PW):0]    cfg_len,
  input  logic [CW-1:0]          cfg_thresh,
  input  logic [CW-1:0]          cfg_window,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   x,
  input  logic                   x_valid,
`ifdef SEQ_DET_CTRL_IRQ_EN
  input  logic                   irq_clr,
  output logic                   irq,
`endif
  output logic                   busy,
  output logic                   hit,
  output logic                   done,
  output logic                   timeout,
  output logic [CW-1:0]          match_cnt
);
  localparam int LW = $clog2(PW) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} state_t;
  state_t st, nxt;
  logic [PW-1:0] pat_q;
  logic [LW-1:0] len_q;
  logic [CW-1:0] thresh_q, window_q, win;
  logic [PW-2:0] hist;
  logic [LW-1:0] seen;
  logic [PW-1:0] cand, mask;
  logic term, expire, enter, step;
  assign cand = {hist, x};
  assign mask = ~({PW{1'b1}} << len_q);
  assign step = st == RUN && x_valid && !abort;
  assign hit = step && seen >= len_q - LW'(1) && ((cand ^ pat_q) & mask) == '0;
  assign term = hit && ({1'b0, match_cnt} + (CW+1)'(1) >= {1'b0, thresh_q});
  assign expire = step && window_q != '0 && ({1'b0, win} + (CW+1)'(1) == {1'b0, window_q});
  assign enter = nxt == RUN && st != RUN;
  assign busy = st == RUN;
  assign done = st == DONE;
  assign timeout = st == TOUT;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = (start && !abort) ? RUN : IDLE;
      RUN:     nxt = abort ? IDLE : term ? DONE : expire ? TOUT : RUN;
      default: nxt = abort ? IDLE : start ? RUN : st;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      pat_q <= '0;
      len_q <= LW'(1);
      thresh_q <= CW'(1);
      window_q <= '0;
      hist <= '0;
      seen <= '0;
      win <= '0;
      match_cnt <= '0;
    end else begin
      st <= nxt;
      if (cfg_we && st != RUN) begin
        pat_q <= cfg_pat;
        len_q <= cfg_len == '0 ? LW'(1) : cfg_len > LW'(PW) ? LW'(PW) : cfg_len;
        thresh_q <= cfg_thresh == '0 ? CW'(1) : cfg_thresh;
        window_q <= cfg_window;
      end
      if (enter) begin
        hist <= '0;
        seen <= '0;
        win <= '0;
        match_cnt <= '0;
      end else if (step) begin
        win <= win + CW'(1);
        match_cnt <= (hit && !(&match_cnt)) ? match_cnt + CW'(1) : match_cnt;
        // non-overlapping mode restarts pattern history after every match
        hist <= (hit && OVERLAP == 0) ? '0 : cand[PW-2:0];
        seen <= (hit && OVERLAP == 0) ? '0 : (seen == LW'(PW)) ? seen : seen + LW'(1);
      end
    end
  end
`ifdef SEQ_DET_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else irq <= ((nxt == DONE || nxt == TOUT) && nxt != st) | (irq & ~irq_clr);
  end
`endif
endmodule
